// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of one single-port synchronous RAM; round-robin by default.
// Define RAM_ARB_FIXED_PRIO_EN to give port A fixed priority when both ports request.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_ack,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  grant_b
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t state;
  logic   wr;
  logic   pick_b;

  // Winner selection for the IDLE edge
  always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    pick_b = b_req & ~a_req;
`else
    pick_b = b_req & (~a_req | ~grant_b);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr       <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      busy     <= 1'b0;
      grant_b  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            grant_b  <= pick_b;
            ram_addr <= pick_b ? b_addr : a_addr;
            ram_din  <= pick_b ? b_wdata : a_wdata;
            ram_we   <= pick_b ? b_we : a_we;
            wr       <= pick_b ? b_we : a_we;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // ram_dout now reflects the address sampled at the end of ACCESS
          if (grant_b) begin
            if (!wr) b_rdata <= ram_dout;
            b_ack <= 1'b1;
          end else begin
            if (!wr) a_rdata <= ram_dout;
            a_ack <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table plus corner sequences, acks checked against a scoreboard.
// Honours RAM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic       a_ack, b_ack, ram_we, busy, grant_b;

  ram_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-first
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic       port;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] rdata;
  } sb_t;

  sb_t  sb[$];
  vec_t vt[10];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  logic [7:0] last_a, last_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ack must match the next expected transaction
  always @(negedge clk) begin
    if (!rst && (a_ack || b_ack)) begin
      sb_t e;
      logic [7:0] want;
      chk("one_ack_only", 32'(a_ack & b_ack), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(a_ack | b_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(b_ack), 32'(e.port));
        if (e.port) begin
          want = e.we ? last_b : e.rdata;
          chk("b_rdata", 32'(b_rdata), 32'(want));
          chk("a_rdata_held", 32'(a_rdata), 32'(last_a));
          last_b = want;
        end else begin
          want = e.we ? last_a : e.rdata;
          chk("a_rdata", 32'(a_rdata), 32'(want));
          chk("b_rdata_held", 32'(b_rdata), 32'(last_b));
          last_a = want;
        end
      end
    end
  end

  task automatic drive(input logic port, input logic we, input logic [5:0] addr, input logic [7:0] wd);
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
  endtask

  // Single uncontended transaction with cycle-exact checks
  task automatic apply(input vec_t v);
    sb_t e;
    @(posedge clk); #1;
    drive(v.port, v.we, v.addr, v.wdata);
    e.port = v.port; e.we = v.we; e.rdata = v.rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("c1_ram_we", 32'(ram_we), 32'(v.we));
    chk("c1_ram_addr", 32'(ram_addr), 32'(v.addr));
    if (v.we) chk("c1_ram_din", 32'(ram_din), 32'(v.wdata));
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_grant_b", 32'(grant_b), 32'(v.port));
    @(posedge clk); #1;
    chk("c2_ram_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    chk("c3_ack", 32'(v.port ? b_ack : a_ack), 32'd1);
    chk("c3_other_ack", 32'(v.port ? a_ack : b_ack), 32'd0);
    if (v.port) b_req = 1'b0; else a_req = 1'b0;
    @(posedge clk); #1;
    chk("c4_idle", 32'({a_ack, b_ack, busy}), 32'd0);
    chk("c4_addr_held", 32'(ram_addr), 32'(v.addr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    last_a = 8'h00; last_b = 8'h00;
    rst = 1'b0;
  endtask

  initial begin
    sb_t e;
    int na, nb, prev, ta, tb2;
    int a_tgt, b_tgt;
    logic fixed;
`ifdef RAM_ARB_FIXED_PRIO_EN
    fixed = 1'b1;
`else
    fixed = 1'b0;
`endif
    vt[0] = '{1'b0, 1'b1, 6'h05, 8'hA5, 8'h00};
    vt[1] = '{1'b0, 1'b0, 6'h05, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 1'b1, 6'h3F, 8'h3C, 8'h00};
    vt[3] = '{1'b1, 1'b0, 6'h3F, 8'h00, 8'h3C};
    vt[4] = '{1'b0, 1'b1, 6'h20, 8'h11, 8'h00};
    vt[5] = '{1'b1, 1'b0, 6'h20, 8'h00, 8'h11};
    vt[6] = '{1'b1, 1'b1, 6'h21, 8'h5A, 8'h00};
    vt[7] = '{1'b0, 1'b0, 6'h21, 8'h00, 8'h5A};
    vt[8] = '{1'b0, 1'b1, 6'h00, 8'hFF, 8'h00};
    vt[9] = '{1'b1, 1'b0, 6'h00, 8'h00, 8'hFF};
    a_we = 0; b_we = 0; a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    do_reset();
    chk("rst_outputs", 32'({ram_we, a_ack, b_ack, busy}), 32'd0);
    chk("rst_ram_addr_din", 32'({ram_addr, ram_din}), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    chk("rst_grant_b", 32'(grant_b), 32'd1);

    for (int i = 0; i < 10; i++) apply(vt[i]);

    // Reset in the middle of a port A write
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 6'h10, 8'h77);
    @(posedge clk); #1;
    chk("abort_we_before", 32'(ram_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_after", 32'(ram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_grant_b", 32'(grant_b), 32'd1);
    a_req = 1'b0;
    last_a = 8'h00; last_b = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", 32'({a_ack, b_ack}), 32'd0);
    end

    // Both ports held: A writes 0x30, B reads 0x30
    a_tgt = fixed ? 4 : 2;
    b_tgt = fixed ? 1 : 2;
    for (int i = 0; i < 5; i++) begin
      if (fixed) begin
        e.port = (i == 4); e.we = (i != 4);
      end else begin
        if (i == 4) break;
        e.port = i[0]; e.we = ~i[0];
      end
      e.rdata = e.we ? 8'h00 : 8'hAA;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 6'h30, 8'hAA);
    drive(1'b1, 1'b0, 6'h30, 8'h00);
    na = 0; nb = 0; prev = -1;
    for (int i = 0; i < 60 && (a_req || b_req); i++) begin
      @(posedge clk); #1;
      if (a_ack || b_ack) begin
        if (prev >= 0) chk("ack_spacing", 32'(cyc - prev), 32'd4);
        prev = cyc;
      end
      if (a_ack) na++;
      if (b_ack) nb++;
      if (a_ack && na == a_tgt) a_req = 1'b0;
      if (b_ack && nb == b_tgt) b_req = 1'b0;
    end
    chk("contend_a_count", 32'(na), 32'(a_tgt));
    chk("contend_b_count", 32'(nb), 32'(b_tgt));
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(posedge clk);

    // B arrives one cycle after A has won
    e.port = 1'b0; e.we = 1'b0; e.rdata = 8'hAA; sb.push_back(e);
    e.port = 1'b1; e.we = 1'b1; e.rdata = 8'h00; sb.push_back(e);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 6'h30, 8'h00);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 6'h31, 8'h42);
    ta = -1; tb2 = -100;
    for (int i = 0; i < 30 && (a_req || b_req); i++) begin
      @(posedge clk); #1;
      if (a_ack) begin ta = cyc; a_req = 1'b0; end
      if (b_ack) begin tb2 = cyc; b_req = 1'b0; end
    end
    chk("late_b_gap", 32'(tb2 - ta), 32'd4);
    a_req = 1'b0; b_req = 1'b0;

    // Port A reads what port B just wrote
    apply('{1'b0, 1'b0, 6'h31, 8'h00, 8'h42});

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
